stream_loader: RTL

Front-end sequencer upstream of the CNN accelerator top. It accepts one inference frame as a valid/ready byte stream: 64 image bytes, then 54 weight bytes. It drives the accelerator's `mode`/`din`/`ram_en` write port, pulses `calc_en`, waits for `out_data_flag`, and returns the captured 8-bit result through a valid/ready result port.

---
 rtl/stream_loader_pkg.sv | 21 ++
 rtl/stream_loader_rise.sv | 28 ++
 rtl/stream_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/stream_loader_pkg.sv
// Shared definitions for the stream_loader front-end sequencer.
//   loader_state_t : sequencer FSM state encoding
//   IMG_BYTES      : default image bytes per frame (8x8x1)
//   WGT_BYTES      : default weight bytes per frame (3x3x3x2)
//   RES_W          : accelerator result width
package stream_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_DATA,
    ST_LOAD_WEIGHT,
    ST_START,
    ST_WAIT,
    ST_RESULT
  } loader_state_t;

  localparam int IMG_BYTES = 64;
  localparam int WGT_BYTES = 54;
  localparam int RES_W     = 8;

endpackage

// File: rtl/stream_loader_rise.sv
// rise_detect: registers a level input and emits a one-cycle pulse on the
// cycle after a 0->1 transition is sampled.
//   clk   : clock
//   rst   : asynchronous active-high reset
//   level : input level (accelerator out_data_flag)
//   pulse : one-cycle rising-edge pulse, registered
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/stream_loader.sv
// stream_loader: accepts one inference frame (image bytes, then weight bytes)
// as a valid/ready byte stream, writes it into the accelerator RAMs, starts the
// accelerator, waits for its done flag and returns the result byte.
//   clk, rst                 : clock, asynchronous active-high reset
//   s_valid/s_data/s_ready   : input byte stream
//   mode/din/ram_en          : accelerator write port (mode 0 data, 1 weight)
//   calc_en                  : accelerator start pulse
//   acc_dout/acc_done        : accelerator result byte and done flag
//   res_valid/res_data/res_ready : result handshake
//   busy, frame_cnt, err     : status
// Optional: define STREAM_LOADER_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYCLES cycles; a timeout sets the sticky err flag and aborts the frame.
module stream_loader
  import stream_loader_pkg::*;
#(
  parameter int DATA_BYTES     = IMG_BYTES,
  parameter int WEIGHT_BYTES   = WGT_BYTES,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             mode,
  output logic [7:0]       din,
  output logic             ram_en,
  output logic             calc_en,
  input  logic [RES_W-1:0] acc_dout,
  input  logic             acc_done,
  output logic             res_valid,
  output logic [RES_W-1:0] res_data,
  input  logic             res_ready,
  output logic             busy,
  output logic [7:0]       frame_cnt,
  output logic             err
);

  localparam int MAX_BYTES = (DATA_BYTES > WEIGHT_BYTES) ? DATA_BYTES : WEIGHT_BYTES;
  localparam int CNT_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);
  localparam logic [CNT_W-1:0] WGT_LAST  = CNT_W'(WEIGHT_BYTES - 1);

  loader_state_t    state, state_next;
  logic [CNT_W-1:0] byte_cnt, cnt_next;
  logic             accept;
  logic             done_pulse;
  logic             timeout;

  rise_detect u_done_edge (
    .clk   (clk),
    .rst   (rst),
    .level (acc_done),
    .pulse (done_pulse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      byte_cnt <= '0;
    end else begin
      state    <= state_next;
      byte_cnt <= cnt_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = byte_cnt;
    s_ready    = (state == ST_IDLE) || (state == ST_LOAD_DATA) ||
                 (state == ST_LOAD_WEIGHT);
    accept     = s_valid && s_ready;
    res_valid  = (state == ST_RESULT);
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        // The accept that leaves IDLE is data byte 0.
        if (accept) begin
          if (DATA_BYTES == 1) begin
            state_next = ST_LOAD_WEIGHT;
            cnt_next   = '0;
          end else begin
            state_next = ST_LOAD_DATA;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      ST_LOAD_DATA: begin
        if (accept) begin
          if (byte_cnt == DATA_LAST) begin
            state_next = ST_LOAD_WEIGHT;
            cnt_next   = '0;
          end else begin
            cnt_next = byte_cnt + CNT_W'(1);
          end
        end
      end
      ST_LOAD_WEIGHT: begin
        if (accept) begin
          if (byte_cnt == WGT_LAST) begin
            state_next = ST_START;
            cnt_next   = '0;
          end else begin
            cnt_next = byte_cnt + CNT_W'(1);
          end
        end
      end
      ST_START: state_next = ST_WAIT;
      ST_WAIT: begin
        if (done_pulse) state_next = ST_RESULT;
        else if (timeout) state_next = ST_IDLE;
      end
      ST_RESULT: begin
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Write port is registered: an accept at cycle t appears at t+1. mode keeps
  // the type of the last written byte between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en    <= 1'b0;
      din       <= '0;
      mode      <= 1'b0;
      calc_en   <= 1'b0;
      res_data  <= '0;
      frame_cnt <= '0;
    end else begin
      ram_en  <= accept;
      if (accept) begin
        din  <= s_data;
        mode <= (state == ST_LOAD_WEIGHT);
      end
      // START is exactly one cycle, so this lands on the first WAIT cycle.
      calc_en <= (state == ST_START);
      if (state == ST_WAIT && done_pulse) res_data <= acc_dout;
      if (state == ST_RESULT && res_ready) frame_cnt <= frame_cnt + 8'd1;
    end
  end

`ifdef STREAM_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] wait_cnt;

  // wait_cnt is 0 in the first WAIT cycle, so TO_LAST marks the last allowed one.
  assign timeout = (state == ST_WAIT) && !done_pulse && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == ST_START) wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + TO_W'(1);
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule
